// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Loop-back monitor for a multiplexed, active-low 7-segment display.
//   It samples the seg/an pins and rebuilds the hex value, the decimal
//   points and the digit enables of each scan frame.
//
//   Optional feature macro: SEVSEG_CAP_ERR_EN
//     defined   - decode_err reports illegal segment patterns and stable
//                 multi-low anodes seen during the frame
//     undefined - the error logic is removed and decode_err is tied to 0
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous, active-low reset
//   seg[7:0]     in   segment pins a..g = seg[0..6], dp = seg[7], active-low, async
//   an[3:0]      in   digit anodes, active-low, async
//   display      out  captured nibbles, digit k = display[4k+3:4k]
//   points       out  captured decimal points, active-high
//   enables      out  1 = digit k was lit in the last frame
//   frame_valid  out  one-clk pulse when the outputs update
//   decode_err   out  error flag for the last frame
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 524288,
  parameter int TIMEOUT_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] display,
  output logic [3:0]  points,
  output logic [3:0]  enables,
  output logic        frame_valid,
  output logic        decode_err
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  // Pin synchroniser plus one history stage; prev_reg is the value being
  // qualified, stab_cnt_reg counts how long it has been held.
  logic [11:0]          sync1_reg, sync2_reg, prev_reg;
  logic [SCW-1:0]       stab_cnt_reg;
  logic [TIMEOUT_W-1:0] to_cnt_reg;

  state_t               state_reg;
  logic [3:0][3:0]      slots_reg;
  logic [3:0]           dp_reg;
  logic [3:0]           seen_reg;
  logic [1:0]           first_reg;

  logic [3:0]  an_low;
  logic        stable_hit, one_low, multi_low, accept;
  logic [1:0]  acc_idx;
  logic [3:0]  acc_mask;
  logic [3:0]  dec_nib;
  logic        dec_ok;
  logic        to_hit, timeout;
  logic        close_err;
  logic [15:0] close_display;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      prev_reg     <= '0;
      stab_cnt_reg <= '0;
    end else begin
      sync1_reg <= {an, seg};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (sync2_reg != prev_reg)
        stab_cnt_reg <= '0;
      else if (stab_cnt_reg != SCW'(STABLE_CYCLES))
        stab_cnt_reg <= stab_cnt_reg + 1'b1;   // saturating, so the hit value is passed once
    end
  end

  assign an_low     = ~prev_reg[11:8];
  assign stable_hit = (stab_cnt_reg == SCW'(STABLE_CYCLES - 1));
  assign one_low    = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
  assign multi_low  = stable_hit && ((an_low & (an_low - 4'd1)) != 4'd0);
  assign accept     = stable_hit && one_low;

  always_comb begin
    acc_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (an_low[i]) acc_idx = 2'(i);
  end

  assign acc_mask = 4'b0001 << acc_idx;

  // Segment pattern (active-high a..g) to hex nibble.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (~prev_reg[6:0])
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Frame timeout; an accept in the same clk takes priority.
  assign to_hit  = (to_cnt_reg == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = to_hit && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt_reg <= '0;
    else if (accept || to_hit)
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_reg + 1'b1;
  end

`ifdef SEVSEG_CAP_ERR_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_reg <= 1'b0;
    else if (accept && (state_reg == IDLE || acc_idx == first_reg))
      err_reg <= !dec_ok;                      // new frame starts
    else if (accept)
      err_reg <= err_reg | !dec_ok;
    else if (multi_low && state_reg == COLLECT)
      err_reg <= 1'b1;
  end

  assign close_err = err_reg;
`else
  assign close_err = 1'b0;
`endif

  // Digits not lit in the frame read as zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign close_display[4*gi +: 4] = seen_reg[gi] ? slots_reg[gi] : 4'h0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      slots_reg   <= '0;
      dp_reg      <= '0;
      seen_reg    <= '0;
      first_reg   <= '0;
      display     <= '0;
      points      <= '0;
      enables     <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (accept) begin
        slots_reg[acc_idx] <= dec_nib;
        dp_reg[acc_idx]    <= ~prev_reg[7];
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            first_reg <= acc_idx;
            seen_reg  <= acc_mask;
            state_reg <= COLLECT;
          end else if (timeout) begin
            // Blank display: publish an empty frame periodically.
            display     <= '0;
            points      <= '0;
            enables     <= '0;
            decode_err  <= 1'b0;
            frame_valid <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept && acc_idx != first_reg) begin
            seen_reg <= seen_reg | acc_mask;
          end else if (accept || timeout) begin
            // Close with the pre-event contents; a repeat of the first
            // digit immediately opens the next frame.
            display     <= close_display;
            points      <= dp_reg & seen_reg;
            enables     <= seen_reg;
            decode_err  <= close_err;
            frame_valid <= 1'b1;
            if (accept) begin
              first_reg <= acc_idx;
              seen_reg  <= acc_mask;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] display;
  logic [3:0]  points;
  logic [3:0]  enables;
  logic        frame_valid;
  logic        decode_err;

  int checks = 0;
  int errors = 0;

  // frame_valid log, written only by the monitor
  int          fv_count = 0;
  int          cyc = 0;
  logic [15:0] fv_disp [0:511];
  logic [3:0]  fv_en   [0:511];
  int          fv_cyc  [0:511];

  seven_seg_capture #(
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(64),
    .TIMEOUT_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg(seg),
    .an(an),
    .display(display),
    .points(points),
    .enables(enables),
    .frame_valid(frame_valid),
    .decode_err(decode_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_disp[fv_count % 512] = display;
      fv_en[fv_count % 512]   = enables;
      fv_cyc[fv_count % 512]  = cyc;
      fv_count                = fv_count + 1;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n - 1) @(negedge clk);
  endtask

  // Drive the closing digit and check that exactly one frame was published.
  task automatic close_frame(input string tag, input logic [15:0] d, input logic [3:0] e,
                             input logic [3:0] p);
    int base;
    base = fv_count;
    drive(4'hE, 8'hC0, 20);
    check({tag, "_pulses"}, fv_count - base, 1);
    check({tag, "_display"}, display, d);
    check({tag, "_enables"}, enables, e);
    check({tag, "_points"}, points, p);
    $display("frame %s display=%h enables=%h points=%h err=%b", tag, display, enables, points,
             decode_err);
  endtask

  initial begin
    int base;
    logic exp_err;
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 8'hFF;
    repeat (5) @(negedge clk);
    check("rst_display", display, 16'h0);
    check("rst_points", points, 4'h0);
    check("rst_enables", enables, 4'h0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_err", decode_err, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: full scan 0,1,2,F
    drive(4'hE, 8'hC0, 20);
    drive(4'hD, 8'hF9, 20);
    drive(4'hB, 8'hA4, 20);
    drive(4'h7, 8'h8E, 20);
    close_frame("scan", 16'hF210, 4'hF, 4'h0);

    // 2: digit2 shows '5' with dp, digit3 dark
    drive(4'hD, 8'hF9, 20);
    drive(4'hB, 8'h12, 20);
    close_frame("partial", 16'h0510, 4'h7, 4'h4);

    // 3: 2-clk anode glitch onto digit3 inside digit1's dwell
    drive(4'hD, 8'hF9, 8);
    drive(4'h7, 8'h8E, 2);
    drive(4'hD, 8'hF9, 10);
    drive(4'hB, 8'hA4, 20);
    close_frame("glitch", 16'h0210, 4'h7, 4'h0);

    // 6: reset mid-frame, then a clean scan
    drive(4'hD, 8'hA4, 20);
    drive(4'hB, 8'hF9, 10);
    base = fv_count;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_display", display, 16'h0);
    check("arst_enables", enables, 4'h0);
    check("arst_points", points, 4'h0);
    check("arst_err", decode_err, 1'b0);
    an  = 4'hF;
    seg = 8'hFF;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_pulse", fv_count - base, 0);
    drive(4'hE, 8'hC0, 20);
    drive(4'hD, 8'hF9, 20);
    drive(4'hB, 8'hA4, 20);
    drive(4'h7, 8'h8E, 20);
    close_frame("after_rst", 16'hF210, 4'hF, 4'h0);

    // 5: blank segments on digit1 and a stable double anode
    drive(4'hD, 8'hFF, 20);
    drive(4'hC, 8'hF9, 10);
    close_frame("bad_seg", 16'h0000, 4'h3, 4'h0);
`ifdef SEVSEG_CAP_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("bad_seg_err", decode_err, exp_err);

    // 4: blank display after a one-digit frame
    drive(4'hE, 8'hF9, 20);
    base = fv_count;
    drive(4'hF, 8'hFF, 200);
    $display("blank pulses=%0d display=%h enables=%h", fv_count - base, display, enables);
    check("blank_pulses", fv_count - base, 3);
    if (fv_count - base >= 3) begin
      check("blank_first_display", fv_disp[base % 512], 16'h0001);
      check("blank_first_enables", fv_en[base % 512], 4'h1);
      check("blank_last_display", fv_disp[(base + 2) % 512], 16'h0);
      check("blank_last_enables", fv_en[(base + 2) % 512], 4'h0);
      check("blank_period", fv_cyc[(base + 2) % 512] - fv_cyc[(base + 1) % 512], 64);
    end
    check("blank_err", decode_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
